// File: rtl/busarb_rr.sv
// N-way round-robin bus arbiter with parked ownership.
// Optional bounded tenure per owner under contention: define BUSARB_TENURE_EN.
module busarb_rr #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         breq,
  output logic [N-1:0]         bgrt,
  output logic [$clog2(N)-1:0] gidx,
  output logic                 gvalid
);

  localparam int          IW = $clog2(N);
  localparam int unsigned NU = N;
  localparam logic [IW:0] NW = (IW+1)'(N);

  logic [IW-1:0] own;
  logic [IW-1:0] own_nxt;
  logic [IW-1:0] rot;
  logic          own_ok;
  logic          own_req;
  logic          others;
  logic          rot_found;

  // Owner decode and rotating search starting just after the owner.
  always_comb begin
    own_ok    = ({1'b0, own} < NW);
    own_req   = 1'b0;
    others    = 1'b0;
    rot       = '0;
    rot_found = 1'b0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (own == IW'(i)) own_req = breq[i];
      else if (breq[i])  others  = 1'b1;
    end
    for (int unsigned k = 1; k < NU; k++) begin
      int unsigned idx;
      idx = (32'(own) + k) % NU;
      if (!rot_found && breq[idx]) begin
        rot       = IW'(idx);
        rot_found = 1'b1;
      end
    end
  end

`ifdef BUSARB_TENURE_EN
  logic [7:0] cnt;
  logic       expire;

  assign expire = own_req && (cnt == 8'(MAX_HOLD - 1)) && others;
`endif

  always_comb begin
    own_nxt = own;
    if (!own_ok)
      own_nxt = '0;
    else if (!own_req && others && rot_found)
      own_nxt = rot;
`ifdef BUSARB_TENURE_EN
    else if (expire && rot_found)
      own_nxt = rot;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) own <= '0;
    else     own <= own_nxt;
  end

`ifdef BUSARB_TENURE_EN
  // Counts consecutive granted cycles of the current owner only.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if ((own_nxt != own) || !own_req)
      cnt <= '0;
    else if (cnt != 8'hFF)
      cnt <= cnt + 8'd1;
  end
`endif

  always_comb begin
    bgrt = '0;
    for (int unsigned i = 0; i < NU; i++)
      bgrt[i] = breq[i] && (own == IW'(i)) && !rst;
  end

  assign gidx   = own;
  assign gvalid = |bgrt;

endmodule
